bus_xfer_ctrl: RTL

Sequencer for the shared tri-state register bus. It accepts register-transfer commands over a valid/ready handshake and issues the per-register `Rout`/`Rin` enables, and the external-driver enable, cycle by cycle. It guarantees that at most one driver is enabled on the bus in any cycle. SWAP is performed through a dedicated scratch register, so the rest of the design never hand-sequences the bus.

---
 rtl/bus_xfer_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - register-bus transfer sequencer (MOV / LOAD / SWAP via scratch register)
module bus_xfer_ctrl #(
    parameter int NREG    = 4,
    parameter int WIDTH   = 4,
    parameter int TMP_IDX = NREG - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_src,
    input  logic [2:0]       cmd_dst,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [NREG-1:0]  Rout,
    output logic [NREG-1:0]  Rin,
    output logic             ext_oe,
    output logic [WIDTH-1:0] ext_data,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] OP_MOV  = 2'd0;
    localparam logic [1:0] OP_SWAP = 2'd1;
    localparam logic [1:0] OP_LOAD = 2'd2;
    localparam logic [2:0] TMP     = 3'(TMP_IDX);

    typedef enum logic [2:0] {S_IDLE, S_MOV, S_LD, S_SW1, S_SW2, S_SW3} state_t;

    state_t     state;
    logic [2:0] src_q;
    logic [2:0] dst_q;

    logic src_ok;
    logic dst_ok;
    logic same;
    logic touches_tmp;

    function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
        onehot = NREG'(1) << idx;
    endfunction

    assign src_ok      = 32'(cmd_src) < NREG;
    assign dst_ok      = 32'(cmd_dst) < NREG;
    assign same        = cmd_src == cmd_dst;
    assign touches_tmp = (cmd_src == TMP) || (cmd_dst == TMP);

    // Readiness follows rst directly so nothing can be accepted while reset is held.
    assign cmd_ready = (state == S_IDLE) && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            Rout     <= '0;
            Rin      <= '0;
            ext_oe   <= 1'b0;
            ext_data <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            Rout   <= '0;
            Rin    <= '0;
            ext_oe <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        src_q <= cmd_src;
                        dst_q <= cmd_dst;
                        case (cmd_op)
                            OP_MOV: begin
                                if (!src_ok || !dst_ok) begin
                                    err <= 1'b1;
                                end else if (same) begin
                                    done <= 1'b1;
                                end else begin
                                    state <= S_MOV;
                                    Rout  <= onehot(cmd_src);
                                    Rin   <= onehot(cmd_dst);
                                end
                            end
                            OP_SWAP: begin
                                if (!src_ok || !dst_ok || touches_tmp) begin
                                    err <= 1'b1;
                                end else if (same) begin
                                    done <= 1'b1;
                                end else begin
                                    state <= S_SW1;
                                    Rout  <= onehot(cmd_src);
                                    Rin   <= onehot(TMP);
                                end
                            end
                            OP_LOAD: begin
                                if (!dst_ok) begin
                                    err <= 1'b1;
                                end else begin
                                    state    <= S_LD;
                                    ext_oe   <= 1'b1;
                                    ext_data <= cmd_data;
                                    Rin      <= onehot(cmd_dst);
                                end
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                S_MOV, S_LD, S_SW3: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
                S_SW1: begin
                    state <= S_SW2;
                    Rout  <= onehot(dst_q);
                    Rin   <= onehot(src_q);
                end
                S_SW2: begin
                    state <= S_SW3;
                    Rout  <= onehot(TMP);
                    Rin   <= onehot(dst_q);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
